data_memory_unit: RTL and testbench
===================================

DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter: ADDR_BITS, 8, RAM word-address width; RAM depth is 2^ADDR_BITS words.
REQ-002 Parameter: FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 Adr  input  16  word address from processor.
REQ-006 DataIn  input  16  write data from processor.
REQ-007 MW  input  1  memory write enable from processor.
REQ-008 DataOut  output  16  read data to processor; combinational from Adr.
REQ-009 TxData  output  16  TX FIFO head word.
REQ-010 TxValid  output  1  TX FIFO not empty.
REQ-011 TxReady  input  1  external consumer accepts the head word.

Function
REQ-012 Address map: RAM at 0x0000 to 2^ADDR_BITS-1, TXDATA at 0xFF00, STATUS at 0xFF01, TIMER at 0xFF02; all other addresses are unmapped.
REQ-013 RAM: a write occurs at posedge CLK when MW=1 and Adr is in RAM range; mem[Adr] <= DataIn.
REQ-014 RAM read: DataOut = mem[Adr] combinationally, with zero cycle latency; a same-cycle write is visible only after the edge.
REQ-015 Unmapped reads return 0x0000; unmapped writes have no effect.
REQ-016 TXDATA write (MW=1, Adr=0xFF00) pushes DataIn to the FIFO tail; a TXDATA read returns 0x0000.
REQ-017 Pop: on posedge when TxValid=1 and TxReady=1, the head entry is removed.
REQ-018 TxValid = (count != 0); TxData = head entry when count != 0, otherwise 0x0000.
REQ-019 Push and pop in the same cycle with count=0: the push is accepted, no pop occurs, and count becomes 1.
REQ-020 Push and pop in the same cycle with 0<count<=FIFO_DEPTH: both take effect and count is unchanged, including when full.
REQ-021 Push with count=FIFO_DEPTH and no pop: the word is dropped, FIFO contents are unchanged, and sticky OVF <= 1.
REQ-022 Pointers wrap modulo FIFO_DEPTH; count ranges 0 to FIFO_DEPTH.
REQ-023 STATUS read = {10'b0, count[2:0] at bits 5:3, OVF at bit 2, full at bit 1, empty at bit 0}; count is zero-extended or truncated to 3 bits.
REQ-024 A STATUS write with DataIn[2]=1 clears OVF; other bits are ignored; a clear and a set in the same cycle leaves OVF=1.
REQ-025 TIMER: a 16-bit free-running counter increments by 1 every cycle and wraps 0xFFFF -> 0x0000.
REQ-026 A TIMER write loads DataIn on that edge instead of incrementing; the next edge increments from the loaded value.
REQ-027 A TIMER read returns the current counter value combinationally.

Reset
REQ-028 With RESET=1 at posedge: count=0, pointers=0, OVF=0, TIMER=0x0000, so TxValid=0 and TxData=0x0000 after the edge.
REQ-029 RESET has priority over MW and TxReady in the same cycle; no push, pop or TIMER load occurs.
REQ-030 RAM contents are unaffected by RESET.
REQ-031 A reset mid-stream discards all queued TX words.

Verification
REQ-032 Write 0x1234 to 0x0005, then set Adr=0x0005 -> DataOut=0x1234 in the following cycle; Adr=0x0006 returns its prior contents.
REQ-033 Push 0xA001..0xA004 with TxReady=0 -> STATUS=0x0022 (count 4, full); a fifth push of 0xA005 -> STATUS=0x0026 (OVF set); then TxReady=1 -> TxData sequence A001, A002, A003, A004, then TxValid=0.
REQ-034 With FIFO full, push 0xB000 while TxReady=1 -> count stays 4, OVF unchanged, 0xB000 emerges fifth.
REQ-035 Write 0xFFFE to TIMER -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 on successive cycles.
REQ-036 Queue 2 words, set OVF, then assert RESET for one cycle -> TxValid=0, STATUS=0x0001, TIMER=0x0000, while RAM contents are retained.
REQ-037 Write STATUS with 0x0004 -> OVF=0; read of 0x1000 -> 0x0000.

Source files
------------

// File: rtl/data_memory_unit.sv
// Processor data memory: word RAM plus memory-mapped TX FIFO, status register and free-running timer.
// Reads are combinational from Adr; every piece of state updates on the rising edge of CLK.
module data_memory_unit #(
    parameter int ADDR_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] Adr,
    input  logic [15:0] DataIn,
    input  logic        MW,
    output logic [15:0] DataOut,
    output logic [15:0] TxData,
    output logic        TxValid,
    input  logic        TxReady
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] RAM_WORDS = 32'(2 ** ADDR_BITS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [15:0] TXDATA_ADDR = 16'hFF00;
    localparam logic [15:0] STATUS_ADDR = 16'hFF01;
    localparam logic [15:0] TIMER_ADDR  = 16'hFF02;

    logic [15:0]      mem [RAM_WORDS];
    logic [15:0]      fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [15:0]      timer;

    logic             in_ram;
    logic [ADDR_BITS-1:0] ram_index;
    logic             empty;
    logic             full;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             ovf_set;
    logic             ovf_clr;
    logic             timer_wr;
    logic [15:0]      count_ext;
    logic [15:0]      status_word;

    assign in_ram    = 32'(Adr) < RAM_WORDS;
    assign ram_index = Adr[ADDR_BITS-1:0];
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);

    assign push_req  = MW && !in_ram && (Adr == TXDATA_ADDR);
    assign pop       = !empty && TxReady;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;
    assign ovf_clr   = MW && !in_ram && (Adr == STATUS_ADDR) && DataIn[2];
    assign timer_wr  = MW && !in_ram && (Adr == TIMER_ADDR);

    assign count_ext   = 16'(count);
    assign status_word = {10'b0, count_ext[2:0], ovf, full, empty};

    assign TxValid = !empty;
    assign TxData  = empty ? 16'h0000 : fifo[rd_ptr];

    always_ff @(posedge CLK) begin
        if (MW && in_ram) begin
            mem[ram_index] <= DataIn;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            timer  <= 16'h0000;
        end else begin
            if (push_ok) begin
                fifo[wr_ptr] <= DataIn;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Setting wins over clearing so an overflow is never lost.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            timer <= timer_wr ? DataIn : timer + 16'h0001;
        end
    end

    always_comb begin
        DataOut = 16'h0000;
        if (in_ram) begin
            DataOut = mem[ram_index];
        end else begin
            case (Adr)
                STATUS_ADDR: DataOut = status_word;
                TIMER_ADDR:  DataOut = timer;
                default:     DataOut = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: RAM, address decode, TX FIFO, status, timer and reset.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later, well away from the edge.
module tb_data_memory_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] Adr;
    logic [15:0] DataIn;
    logic        MW;
    logic [15:0] DataOut;
    logic [15:0] TxData;
    logic        TxValid;
    logic        TxReady;

    int errors = 0;
    int checks = 0;

    data_memory_unit #(.ADDR_BITS(8), .FIFO_DEPTH(4)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Adr     (Adr),
        .DataIn  (DataIn),
        .MW      (MW),
        .DataOut (DataOut),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic rdy);
        Adr     = a;
        DataIn  = d;
        MW      = w;
        TxReady = rdy;
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        RESET = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("reset_status", DataOut, 16'h0001);
        check("reset_txvalid", {15'b0, TxValid}, 16'h0000);
        check("reset_txdata", TxData, 16'h0000);
        drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
        check("reset_timer", DataOut, 16'h0000);
        RESET = 1'b0;

        // RAM write/read, same-cycle write not visible until the edge
        drive(16'h0006, 16'hBEEF, 1'b1, 1'b0); tick();
        drive(16'h0005, 16'h1111, 1'b1, 1'b0); tick();
        drive(16'h0005, 16'h1234, 1'b1, 1'b0);
        check("ram_before_edge", DataOut, 16'h1111);
        tick();
        drive(16'h0005, 16'h0000, 1'b0, 1'b0);
        check("ram_addr5", DataOut, 16'h1234);
        drive(16'h0006, 16'h0000, 1'b0, 1'b0);
        check("ram_addr6", DataOut, 16'hBEEF);

        // RAM boundary and unmapped accesses
        drive(16'h0000, 16'h5555, 1'b1, 1'b0); tick();
        drive(16'h00FF, 16'h7E7E, 1'b1, 1'b0); tick();
        drive(16'h1000, 16'hDEAD, 1'b1, 1'b0); tick();
        drive(16'h0100, 16'hDEAD, 1'b1, 1'b0); tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        check("ram_no_alias", DataOut, 16'h5555);
        drive(16'h00FF, 16'h0000, 1'b0, 1'b0);
        check("ram_top", DataOut, 16'h7E7E);
        drive(16'h0100, 16'h0000, 1'b0, 1'b0);
        check("unmapped_0100", DataOut, 16'h0000);
        drive(16'h1000, 16'h0000, 1'b0, 1'b0);
        check("unmapped_1000", DataOut, 16'h0000);
        drive(16'hFF00, 16'h0000, 1'b0, 1'b0);
        check("txdata_read", DataOut, 16'h0000);
        check("still_empty", {15'b0, TxValid}, 16'h0000);

        // Fill, overflow, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(16'hFF00, 16'hA000 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("status_full", DataOut, 16'h0022);
        drive(16'hFF00, 16'hA005, 1'b1, 1'b0); tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("status_ovf", DataOut, 16'h0026);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_a", TxData, 16'hA000 + 16'(i));
            tick();
        end
        check("drain_a_done", {15'b0, TxValid}, 16'h0000);
        check("drain_a_txdata", TxData, 16'h0000);
        check("status_empty_ovf", DataOut, 16'h0005);

        // Clear OVF through STATUS
        drive(16'hFF01, 16'h0004, 1'b1, 1'b0); tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("ovf_cleared", DataOut, 16'h0001);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) begin
            drive(16'hFF00, 16'hC000 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'hFF00, 16'hB000, 1'b1, 1'b1);
        check("full_head", TxData, 16'hC001);
        tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("full_pushpop_status", DataOut, 16'h0022);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
        check("drain_c2", TxData, 16'hC002); tick();
        check("drain_c3", TxData, 16'hC003); tick();
        check("drain_c4", TxData, 16'hC004); tick();
        check("drain_b000", TxData, 16'hB000); tick();
        check("drain_c_done", {15'b0, TxValid}, 16'h0000);

        // Push with pop request on an empty FIFO
        drive(16'hFF00, 16'hD001, 1'b1, 1'b1); tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("empty_pushpop_data", TxData, 16'hD001);
        check("empty_pushpop_status", DataOut, 16'h0008);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b1); tick();
        check("empty_pushpop_drain", DataOut, 16'h0001);

        // Timer load and wrap
        drive(16'hFF02, 16'hFFFE, 1'b1, 1'b0); tick();
        drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
        check("timer_fffe", DataOut, 16'hFFFE); tick();
        check("timer_ffff", DataOut, 16'hFFFF); tick();
        check("timer_0000", DataOut, 16'h0000); tick();
        check("timer_0001", DataOut, 16'h0001);

        // Reset mid-stream with OVF set, competing with a timer load and a pop
        for (int i = 1; i <= 5; i++) begin
            drive(16'hFF00, 16'hE000 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("pre_reset_status", DataOut, 16'h0026);
        RESET = 1'b1;
        drive(16'hFF02, 16'h7777, 1'b1, 1'b1); tick();
        RESET = 1'b0;
        drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
        check("rst_timer", DataOut, 16'h0000);
        check("rst_txvalid", {15'b0, TxValid}, 16'h0000);
        check("rst_txdata", TxData, 16'h0000);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0);
        check("rst_status", DataOut, 16'h0001);
        drive(16'h0005, 16'h0000, 1'b0, 1'b0);
        check("rst_ram_kept", DataOut, 16'h1234);
        tick();
        drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
        check("timer_after_rst", DataOut, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
